st_sample_i2s_tx: RTL and testbench
===================================

# st_sample_i2s_tx

Avalon-ST sink that consumes the 96 kHz sample stream produced by the synthesizer top's source interface. Each stream word carries a 24-bit sample with its bytes swapped. The block restores the byte order, buffers samples in a small synchronous FIFO and serialises them as mono I2S (the same sample on left and right) to an external codec. It is the receiving end of the synthesizer's sample stream.

## Interface
- CLK_HZ, 100_000_000: clk frequency in Hz.
- FS, 96_000: audio frame rate in Hz.
- FIFO_DEPTH, 16: sample buffer depth; must be a power of two, at least 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- asi_data  in  32  stream word {8'bx, s[7:0], s[15:8], s[23:16]}.
- asi_valid  in  1  stream word valid.
- asi_ready  out  1  sink can accept; registered.
- o_bclk  out  1  I2S bit clock, 64×FS.
- o_lrclk  out  1  word select; 0 = left, 1 = right.
- o_sdata  out  1  serial data, MSB first.
- o_underrun  out  1  one-clk pulse when a frame starts with the FIFO empty.
- o_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

## Operation
- Unswap: sample = {asi_data[7:0], asi_data[15:8], asi_data[23:16]}, signed 24-bit. asi_data[31:24] is ignored.
- Push:
  - A word is pushed when asi_valid && asi_ready at a clk edge.
  - asi_ready <= (level_next < FIFO_DEPTH), so ready drops in the cycle after the FIFO fills.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- Tick generator:
  - Phase accumulator acc of width ≥ $clog2(CLK_HZ)+1.
  - Each clk: acc += 128·FS. If the result is ≥ CLK_HZ, subtract CLK_HZ and assert tick.
  - Each tick toggles o_bclk.
- Bit counter bc (6 bits) advances on each tick that drives o_bclk 1→0 (falling edge); wraps 63→0.
- o_lrclk = bc[5]. Slot position p = bc[4:0].
- o_sdata = out_reg[24-p] for p in 1..24, else 0. This gives the I2S one-bit delay after an LRCLK edge and 7 trailing zero bits.
- Pop:
  - On the falling-edge tick where bc goes 63→0, the FIFO head is popped into out_reg (24 bits).
  - The right slot reuses out_reg.
- Underrun: if the FIFO is empty at the pop, out_reg <= 0 and o_underrun pulses for 1 clk.
- Simultaneous push and pop:
  - Both take effect; level is unchanged.
  - The empty check uses the level before that cycle's push: a push into an empty FIFO in the pop cycle still yields an underrun, and the word is kept for the next frame.

## Timing
- Reset values:
  - asi_ready = 0, o_bclk = 0, o_lrclk = 0, o_sdata = 0, o_underrun = 0, o_level = 0.
  - acc = 0, bc = 63, out_reg = 0, FIFO flushed.
- After reset deasserts, asi_ready = 1 from the first clk edge.
- The first falling-edge tick sets bc = 0 and pops immediately.
- Reset mid-frame aborts the frame and discards all buffered samples. Outputs return to reset values asynchronously.
- All outputs are registered.
  - o_lrclk and o_sdata change on the same clk edge as the o_bclk falling transition.
  - Both are stable through the following o_bclk rising edge.
- Push-to-level latency: 1 clk. Pop-to-o_sdata MSB latency: 1 falling bclk (p = 1).
- Long-run tick rate is exactly 128·FS per second. Jitter is at most 1 clk.

## Structure
- Shared synth package holds:
  - SAMPLE_W = 24, BCLK_PER_FRAME = 64, SLOT_W = 32.
  - The byte-unswap function, which is also used by any future stream consumer.
- One sub-module: sample_fifo_sync, a parameterised FIFO with width and depth parameters, push, pop, level, full and empty.
- Tick generator, bit counter and serialiser live in the top of this block.

## Test plan
Configuration: CLK_HZ = 12_288_000, FS = 96_000 (one tick per clk), FIFO_DEPTH = 4, unless stated otherwise.
- Byte order: push asi_data 0x00_56_34_12, then capture the left slot. Required: o_sdata bits p = 1..24 read 0x123456 MSB first, p = 0 and 25..31 are 0, and the right slot is identical.
- Backpressure: hold asi_valid = 1 with no pops (hold bc before wrap by pausing from reset). Required: exactly 4 words accepted, asi_ready = 0 one clk after the 4th push, o_level = 4.
- Underrun: run with no pushes. Required: o_underrun pulses once per 64 bclk, o_sdata stays 0, and the next pushed 0x00_FF_FF_7F is output as 0x7FFFFF in the following frame.
- Simultaneous push and pop:
  - Push exactly at bc 63→0 with level 2: o_level stays 2 and no underrun.
  - Same with level 0: underrun pulses and o_level = 1 afterwards.
- Rate: default CLK_HZ = 100 MHz for 1 ms of clk. Required: 96 o_lrclk periods ±1 and 12288 ±1 o_bclk toggles.
- Reset mid-frame at bc = 40 with 3 samples buffered. Required: all outputs 0 immediately, o_level = 0, and the first frame after release pops from an empty FIFO and underruns.

Source files
------------

// File: rtl/st_sample_i2s_tx_pkg.sv
// Shared synth stream definitions: sample geometry and the byte-unswap helper
// used by every consumer of the synthesizer's Avalon-ST sample stream.
package st_sample_i2s_tx_pkg;

  localparam int SAMPLE_W       = 24;
  localparam int BCLK_PER_FRAME = 64;
  localparam int SLOT_W         = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Stream words carry {pad, s[7:0], s[15:8], s[23:16]}; this restores s.
  function automatic sample_t unswap_sample(input logic [23:0] word);
    return {word[7:0], word[15:8], word[23:16]};
  endfunction

endpackage

// File: rtl/st_sample_i2s_tx_fifo.sv
// sample_fifo_sync: single-clock FIFO, head visible combinationally, level 1 clk after push/pop.
// Pushes while full are dropped unless a pop frees the slot in the same cycle.
module sample_fifo_sync #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/st_sample_i2s_tx.sv
// Avalon-ST sample sink -> mono I2S transmitter; one sample popped per 64-bclk frame.
// asi_ready is registered and drops the cycle after the FIFO fills.
module st_sample_i2s_tx
  import st_sample_i2s_tx_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int FS         = 96_000,
  parameter int FIFO_DEPTH = 16,
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      asi_data,
  input  logic             asi_valid,
  output logic             asi_ready,
  output logic             o_bclk,
  output logic             o_lrclk,
  output logic             o_sdata,
  output logic             o_underrun,
  output logic [LVL_W-1:0] o_level
);

  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam logic [ACC_W:0] INC = (ACC_W + 1)'(128 * FS);
  localparam logic [ACC_W:0] LIM = (ACC_W + 1)'(CLK_HZ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic             tick;
  logic             fall;
  logic [5:0]       bc;
  logic [5:0]       bc_next;
  logic             pop_slot;
  logic             push;
  logic             pop;
  sample_t          head;
  sample_t          out_reg;
  logic [LVL_W-1:0] level_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic [4:0]       slot_p;
  logic [4:0]       bit_idx;
  logic             sdata_next;
  logic             unused_pad;

  assign unused_pad = ^asi_data[31:24];

  always_comb begin
    acc_sum  = {1'b0, acc} + INC;
    tick     = (acc_sum >= LIM);
    fall     = tick && o_bclk;
    bc_next  = bc + 6'd1;
    pop_slot = fall && (bc == 6'd63);
  end

  assign push       = asi_valid && asi_ready && !fifo_full;
  assign pop        = pop_slot && !fifo_empty;
  assign level_next = o_level + LVL_W'(push) - LVL_W'(pop);

  // Slot bit 0 is the I2S one-bit delay; bits 25..31 pad with zeros.
  always_comb begin
    slot_p     = bc_next[4:0];
    bit_idx    = 5'd24 - slot_p;
    sdata_next = 1'b0;
    if (slot_p >= 5'd1 && slot_p <= 5'd24) sdata_next = out_reg[bit_idx];
  end

  sample_fifo_sync #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (unswap_sample(asi_data[23:0])),
    .pop       (pop),
    .head      (head),
    .level     (o_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      bc         <= 6'd63;
      o_bclk     <= 1'b0;
      o_lrclk    <= 1'b0;
      o_sdata    <= 1'b0;
      o_underrun <= 1'b0;
      out_reg    <= '0;
      asi_ready  <= 1'b0;
    end else begin
      acc        <= tick ? ACC_W'(acc_sum - LIM) : ACC_W'(acc_sum);
      asi_ready  <= (level_next < LVL_W'(FIFO_DEPTH));
      o_underrun <= 1'b0;
      if (tick) o_bclk <= !o_bclk;
      if (fall) begin
        bc      <= bc_next;
        o_lrclk <= bc_next[5];
        o_sdata <= sdata_next;
        // Empty check uses pre-push level, so a same-cycle push waits a frame.
        if (pop_slot) begin
          out_reg    <= fifo_empty ? '0 : head;
          o_underrun <= fifo_empty;
        end
      end
    end
  end

endmodule

// File: tb/tb_st_sample_i2s_tx.sv
// Directed bench: dut runs one tick per clk (FIFO_DEPTH 4); dut_rate uses defaults for the tick-rate check.
module tb_st_sample_i2s_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rst_b;
  logic [31:0] asi_data;
  logic        asi_valid;
  logic        asi_ready;
  logic        bclk, lrclk, sdata, underrun;
  logic [2:0]  level;
  logic        ready_b, bclk_b, lrclk_b, sdata_b, underrun_b;
  logic [4:0]  level_b;

  st_sample_i2s_tx #(.CLK_HZ(12_288_000), .FS(96_000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(rst), .asi_data(asi_data), .asi_valid(asi_valid),
    .asi_ready(asi_ready), .o_bclk(bclk), .o_lrclk(lrclk), .o_sdata(sdata),
    .o_underrun(underrun), .o_level(level)
  );

  st_sample_i2s_tx dut_rate (
    .clk(clk), .reset(rst_b), .asi_data(32'h0), .asi_valid(1'b0),
    .asi_ready(ready_b), .o_bclk(bclk_b), .o_lrclk(lrclk_b), .o_sdata(sdata_b),
    .o_underrun(underrun_b), .o_level(level_b)
  );

  int tests = 0;
  int fails = 0;
  int cyc, sch_lo, sch_hi, wi, burst_acc;
  int lr_err, stab_err, ur_cnt;
  logic rdy4;
  logic [31:0] words [9];
  logic [31:0] l, r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clk; drives the scheduled push word and tracks acceptance.
  task automatic clk_step();
    logic took;
    if (cyc + 1 >= sch_lo && cyc + 1 < sch_hi) begin
      asi_valid = 1'b1;
      asi_data  = words[wi];
    end else begin
      asi_valid = 1'b0;
      asi_data  = 32'h0;
    end
    took = asi_valid && asi_ready;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (took) begin
      wi++;
      burst_acc++;
      if (burst_acc == 4) rdy4 = asi_ready;
    end
  endtask

  task automatic run_to(input int e);
    while (cyc < e) clk_step();
  endtask

  // Called just after a pop edge; k even = falling bclk (slot bit p = k/2).
  task automatic cap_frame(input int nk, output logic [31:0] lo, output logic [31:0] ro);
    int p;
    logic prev;
    lo = '0;
    ro = '0;
    prev = 1'b0;
    for (int k = 0; k < nk; k++) begin
      if (k > 0) clk_step();
      p = k / 2;
      if (k % 2 == 0) begin
        if (p < 32) lo[31-p] = sdata;
        else        ro[63-p] = sdata;
        if (lrclk !== (p >= 32)) lr_err++;
      end else if (sdata !== prev) begin
        stab_err++;
      end
      prev = sdata;
      if (k > 0 && underrun) ur_cnt++;
    end
  endtask

  initial begin
    int tog, lrp, urb;
    logic pb, plr, sd_or;
    rst = 1'b1; rst_b = 1'b1;
    asi_valid = 1'b0; asi_data = 32'h0;
    cyc = 0; sch_lo = 0; sch_hi = 0; wi = 0; burst_acc = 0; rdy4 = 1'b1;
    lr_err = 0; stab_err = 0; ur_cnt = 0;
    words[0] = 32'h0056_3412; words[1] = 32'h00FF_FF7F;
    words[2] = 32'h0000_0011; words[3] = 32'h0000_0022;
    words[4] = 32'hA500_0033; words[5] = 32'h0000_0044;
    words[6] = 32'h0000_0055; words[7] = 32'h0000_0066;
    words[8] = 32'h0000_0077;

    repeat (3) @(negedge clk);
    check("rst_ready", asi_ready, 0);
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 0);
    check("rst_sdata", sdata, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", level, 0);

    rst = 1'b0;
    cyc = 0;
    clk_step();
    check("e1_ready", asi_ready, 1);
    check("e1_bclk", bclk, 1);
    check("e1_level", level, 0);

    // Push into an empty FIFO on the very first pop edge.
    sch_lo = 2; sch_hi = 3;
    clk_step();
    check("pp0_underrun", underrun, 1);
    check("pp0_level", level, 1);
    check("pp0_bclk", bclk, 0);
    clk_step();
    check("pp0_pulse_end", underrun, 0);

    run_to(130);
    check("f1_underrun", underrun, 0);
    check("f1_level", level, 0);
    cap_frame(128, l, r);
    check("byte_left", l, 32'h091A_2B00);
    check("byte_right", r, 32'h091A_2B00);
    check("f1_lrclk", lr_err, 0);
    check("f1_stable", stab_err, 0);
    check("f1_no_underrun", ur_cnt, 0);

    clk_step();
    check("ur_pulse", underrun, 1);
    sch_lo = 300; sch_hi = 301; ur_cnt = 0;
    cap_frame(128, l, r);
    check("ur_left_zero", l, 0);
    check("ur_right_zero", r, 0);
    check("ur_single_pulse", ur_cnt, 0);
    check("ur_level", level, 1);

    clk_step();
    check("f3_underrun", underrun, 0);
    check("f3_level", level, 0);
    sch_lo = 400; sch_hi = 408; burst_acc = 0;
    cap_frame(128, l, r);
    check("maxpos_left", l, 32'h3FFF_FF80);
    check("bp_accepted", burst_acc, 4);
    check("bp_ready_after4", rdy4, 0);
    check("bp_level", level, 4);
    check("bp_ready_hold", asi_ready, 0);

    clk_step();
    check("f4_level", level, 3);
    check("f4_ready", asi_ready, 1);
    cap_frame(128, l, r);
    check("f4_left", l, 32'h0880_0000);

    clk_step();
    check("f5_level", level, 2);
    sch_lo = 770; sch_hi = 771;
    run_to(770);
    check("pp2_level", level, 2);
    check("pp2_underrun", underrun, 0);
    sch_lo = 800; sch_hi = 801;
    cap_frame(81, l, r);
    check("f6_left", l, 32'h1980_0000);
    check("bc40_lrclk", lrclk, 1);
    check("bc40_level", level, 3);

    rst = 1'b1;
    #1;
    check("mid_rst_ready", asi_ready, 0);
    check("mid_rst_bclk", bclk, 0);
    check("mid_rst_lrclk", lrclk, 0);
    check("mid_rst_sdata", sdata, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_level", level, 0);
    @(negedge clk);
    @(negedge clk);
    sch_lo = 0; sch_hi = 0;
    rst = 1'b0;
    cyc = 0;
    clk_step();
    clk_step();
    check("post_rst_underrun", underrun, 1);
    check("post_rst_level", level, 0);

    @(negedge clk);
    rst_b = 1'b0;
    tog = 0; lrp = 0; urb = 0;
    pb = bclk_b; plr = lrclk_b; sd_or = 1'b0;
    for (int n = 0; n < 6250; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bclk_b !== pb) tog++;
      if (lrclk_b === 1'b1 && plr === 1'b0) lrp++;
      if (underrun_b) urb++;
      sd_or = sd_or | sdata_b;
      pb = bclk_b;
      plr = lrclk_b;
    end
    check("rate_bclk_toggles", (tog >= 767 && tog <= 769), 1);
    check("rate_lrclk_periods", (lrp >= 5 && lrp <= 7), 1);
    check("rate_underruns", urb, 6);
    check("rate_sdata_zero", sd_or, 0);
    check("rate_ready", ready_b, 1);
    check("rate_level", level_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
